dmem_sized: RTL

Parametrised data memory for the MIPS datapath: byte-addressed, 32-bit words, byte/half/word loads and stores with sign or zero extension, a req/ack handshake with configurable wait states, and a hardware clear sequence after reset. It replaces the fixed 32-word, word-only, zero-latency data memory and sits behind the MEM stage of the pipeline.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_sized.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the sized data memory: access-size encodings, FSM states
// and lane geometry.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_IDLE  = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    localparam int LANES      = 4;
    localparam int WAIT_CNT_W = 3;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store lane mask and replicated
// write word, load right-alignment with sign/zero extension, misalign flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]       i_size,
    input  logic [1:0]       i_addr_lo,
    input  logic [31:0]      i_wdata,
    input  logic [31:0]      i_rword,
    input  logic             i_unsigned_ld,
    input  logic             i_check_align,
    output logic [LANES-1:0] o_lane_mask,
    output logic [31:0]      o_wword,
    output logic [31:0]      o_ld_data,
    output logic             o_misalign
);

    logic [1:0]  w_lo;
    logic [31:0] w_shifted;

    // Sub-word data is replicated across all lanes so the mask alone picks the target.
    always_comb begin
        w_lo        = i_addr_lo;
        o_lane_mask = '0;
        o_wword     = i_wdata;
        o_misalign  = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_lane_mask = 4'b0001 << i_addr_lo;
                o_wword     = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_lo        = {i_addr_lo[1], 1'b0};
                o_lane_mask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword     = {2{i_wdata[15:0]}};
                o_misalign  = i_check_align & i_addr_lo[0];
            end
            SZ_WORD: begin
                w_lo        = 2'b00;
                o_lane_mask = 4'b1111;
                o_misalign  = i_check_align & (|i_addr_lo);
            end
            default: begin
                o_lane_mask = '0;
            end
        endcase
    end

    assign w_shifted = i_rword >> {w_lo, 3'b000};

    always_comb begin
        o_ld_data = i_rword;
        case (i_size)
            SZ_BYTE: o_ld_data = {{24{~i_unsigned_ld & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: o_ld_data = {{16{~i_unsigned_ld & w_shifted[15]}}, w_shifted[15:0]};
            default: o_ld_data = i_rword;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressed data memory with sized loads/stores, req/ack wait states and
// a clear sweep after reset. Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
//
// state    | meaning
// CLEAR    | zeroing one word per cycle after reset, requests ignored
// IDLE     | ready; a request is latched here
// WAIT     | counting down the configured wait states
// RESP     | access done on entry; ack (and err) high for this cycle
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [WAIT_CNT_W-1:0] WS_LOAD  = WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    state_e                r_state;
    state_e                w_next;
    logic [IDX_W-1:0]      r_clr_cnt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    logic                  r_we;
    logic                  r_uns;
    logic [1:0]            r_size;
    logic [ADDR_W-1:0]     r_addr;
    logic [31:0]           r_wdata;

    logic [31:0]           r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_do_access;
    logic                  w_clear_wr;
    logic                  w_a_we;
    logic                  w_a_uns;
    logic [1:0]            w_a_size;
    logic [ADDR_W-1:0]     w_a_addr;
    logic [31:0]           w_a_wdata;
    logic [IDX_W-1:0]      w_a_idx;
    logic [31:0]           w_rword;
    logic [LANES-1:0]      w_lane_mask;
    logic [31:0]           w_wword;
    logic [31:0]           w_ld_data;
    logic                  w_misalign;
    logic                  w_reject;
    logic                  w_mem_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_do_access = 1'b0;
        w_clear_wr  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clear_wr = 1'b1;
                if (r_clr_cnt == LAST_IDX) begin
                    w_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    if (HAS_WAIT) begin
                        w_next = ST_WAIT;
                    end else begin
                        w_next      = ST_RESP;
                        w_do_access = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_next      = ST_RESP;
                    w_do_access = 1'b1;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_CLEAR;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (w_clear_wr) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= WS_LOAD;
        end else if (r_state == ST_WAIT && r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= we;
            r_uns   <= unsigned_ld;
            r_size  <= size;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // With no wait states the access happens on the accepting edge, so use the live inputs.
    assign w_a_we    = (r_state == ST_IDLE) ? we          : r_we;
    assign w_a_uns   = (r_state == ST_IDLE) ? unsigned_ld : r_uns;
    assign w_a_size  = (r_state == ST_IDLE) ? size        : r_size;
    assign w_a_addr  = (r_state == ST_IDLE) ? addr        : r_addr;
    assign w_a_wdata = (r_state == ST_IDLE) ? wdata       : r_wdata;
    assign w_a_idx   = w_a_addr[ADDR_W-1:2];
    assign w_rword   = r_mem[w_a_idx];

    dmem_lane_align u_lane_align (
        .i_size        (w_a_size),
        .i_addr_lo     (w_a_addr[1:0]),
        .i_wdata       (w_a_wdata),
        .i_rword       (w_rword),
        .i_unsigned_ld (w_a_uns),
        .i_check_align (ALIGN_CHK),
        .o_lane_mask   (w_lane_mask),
        .o_wword       (w_wword),
        .o_ld_data     (w_ld_data),
        .o_misalign    (w_misalign)
    );

    assign w_reject = (w_a_size == SZ_RSVD) || w_misalign;
    assign w_mem_wr = w_do_access && w_a_we && !w_reject;

    always_ff @(posedge clk) begin
        if (w_clear_wr) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_mem_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_lane_mask[i]) begin
                    r_mem[w_a_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= w_do_access;
            err <= w_do_access & w_reject;
            if (w_do_access && !w_a_we && !w_reject) begin
                rdata <= w_ld_data;
            end
        end
    end

endmodule
